tdm_demux8_nibble: RTL and testbench

- Receiving end of the team's 8-channel time-division nibble link; performs the inverse of the 8:1 nibble multiplexer.
- Accepts one WIDTH-bit word per handshake, tagged with a 3-bit select code, and routes it into one of eight per-channel holding registers.
- Once all eight channels have been written, it presents the full frame with a valid/ready handshake and stalls the link until the frame is consumed.

---
 rtl/tdm_demux8_nibble.sv | 122 ++++++++++++
 tb/tb_tdm_demux8_nibble.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8_nibble.sv
// Receive side of the 8-channel TDM nibble link: steers tagged words into
// per-channel holding registers and hands off each complete frame via valid/ready.
module tdm_demux8_nibble #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  output logic [WIDTH-1:0] f0,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2,
  output logic [WIDTH-1:0] f3,
  output logic [WIDTH-1:0] f4,
  output logic [WIDTH-1:0] f5,
  output logic [WIDTH-1:0] f6,
  output logic [WIDTH-1:0] f7,
  output logic [7:0]       written_mask,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             dup_err,
  input  logic             clr_err
);

  localparam int unsigned NCH = 8;
  localparam int unsigned CHW = 3;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] f_q [NCH];
  logic [WIDTH-1:0] f_d [NCH];
  logic [NCH-1:0]   mask_q, mask_d;
  logic             dup_q, dup_d;
  logic             in_ready_q, in_ready_d;
  logic             frame_valid_q, frame_valid_d;

  logic [CHW-1:0]   ch_c;
  logic             wr_c;
  logic             dup_hit_c;

  // Link select code to channel index; matches the mux side bit-for-bit.
  always_comb begin
    ch_c = 3'd0;
    unique case (in_sel)
      3'b000: ch_c = 3'd0;
      3'b001: ch_c = 3'd1;
      3'b010: ch_c = 3'd2;
      3'b100: ch_c = 3'd3;
      3'b011: ch_c = 3'd4;
      3'b101: ch_c = 3'd5;
      3'b110: ch_c = 3'd6;
      3'b111: ch_c = 3'd7;
    endcase
  end

  assign wr_c = in_valid & in_ready_q;

  // Next-state: capture words in COLLECT, freeze everything in HOLD.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    f_d       = f_q;
    dup_hit_c = 1'b0;

    if (state_q == COLLECT) begin
      if (wr_c) begin
        f_d[ch_c]    = in_data;
        dup_hit_c    = mask_q[ch_c];
        mask_d[ch_c] = 1'b1;
        if (&mask_d) begin
          state_d = HOLD;
        end
      end
    end else begin
      if (frame_ready) begin
        state_d = COLLECT;
        mask_d  = '0;
      end
    end

    // A duplicate in the same cycle as a clear still leaves the flag set.
    dup_d         = (dup_q & ~clr_err) | dup_hit_c;
    in_ready_d    = (state_d == COLLECT);
    frame_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      f_q           <= '{default: '0};
      mask_q        <= '0;
      dup_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      f_q           <= f_d;
      mask_q        <= mask_d;
      dup_q         <= dup_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign f0           = f_q[0];
  assign f1           = f_q[1];
  assign f2           = f_q[2];
  assign f3           = f_q[3];
  assign f4           = f_q[4];
  assign f5           = f_q[5];
  assign f6           = f_q[6];
  assign f7           = f_q[7];
  assign written_mask = mask_q;
  assign frame_valid  = frame_valid_q;
  assign in_ready     = in_ready_q;
  assign dup_err      = dup_q;

endmodule

// File: tb/tb_tdm_demux8_nibble.sv
// Bench for tdm_demux8_nibble: directed scenarios plus random traffic checked
// against a frame-level model of the demultiplexer.
module tb_tdm_demux8_nibble;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_sel;
  logic [3:0] f_w [8];
  logic [7:0] written_mask;
  logic       frame_valid;
  logic       frame_ready;
  logic       dup_err;
  logic       clr_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] exp_f [8];
  bit         exp_w [8];
  bit         exp_fv;
  bit         exp_dup;
  int         code2ch [8] = '{0, 1, 2, 4, 3, 5, 6, 7};
  int         ch2code [8] = '{0, 1, 2, 4, 3, 5, 6, 7};

  tdm_demux8_nibble #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .f0(f_w[0]), .f1(f_w[1]), .f2(f_w[2]), .f3(f_w[3]),
    .f4(f_w[4]), .f5(f_w[5]), .f6(f_w[6]), .f7(f_w[7]),
    .written_mask(written_mask), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .dup_err(dup_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = exp_w[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      exp_f[i] = 4'h0;
      exp_w[i] = 1'b0;
    end
    exp_fv  = 1'b0;
    exp_dup = 1'b0;
  endtask

  // One clock of frame-level behaviour, evaluated on the pre-edge model state.
  task automatic model_clock(input bit v, input logic [2:0] s, input logic [3:0] d,
                             input bit fr, input bit clr);
    bit hit;
    int cnt;
    int ch;
    hit = 1'b0;
    if (!exp_fv) begin
      if (v) begin
        ch        = code2ch[s];
        hit       = exp_w[ch];
        exp_f[ch] = d;
        exp_w[ch] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(exp_w[i]);
        if (cnt == 8) exp_fv = 1'b1;
      end
    end else if (fr) begin
      exp_fv = 1'b0;
      for (int i = 0; i < 8; i++) exp_w[i] = 1'b0;
    end
    if (hit) exp_dup = 1'b1;
    else if (clr) exp_dup = 1'b0;
  endtask

  task automatic step(input bit v, input logic [2:0] s, input logic [3:0] d,
                      input bit fr, input bit clr);
    in_valid    = v;
    in_sel      = s;
    in_data     = d;
    frame_ready = fr;
    clr_err     = clr;
    @(posedge clk);
    model_clock(v, s, d, fr, clr);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sel = 3'd0; in_data = 4'h0; frame_ready = 1'b0; clr_err = 1'b0;
  endtask

  // Writes every channel not yet written this frame, then accepts the frame.
  task automatic finish_and_accept();
    for (int c = 0; c < 8; c++)
      if (!exp_w[c]) step(1'b1, 3'(ch2code[c]), 4'($urandom), 1'b0, 1'b0);
    step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (f_w[i] !== 4'h0) begin
        n_errors++; $display("FAIL reset_f%0d: got %h expected 0", i, f_w[i]);
      end
    end
    n_checks++;
    if ({written_mask, frame_valid, dup_err} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_flags: mask=%h fv=%b dup=%b expected all 0", written_mask, frame_valid, dup_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(ch2code[i]), 4'(i), 1'b0, 1'b0);
      n_checks++;
      if (frame_valid !== (i == 7)) begin
        n_errors++; $display("FAIL basic_fv_w%0d: got %b expected %b", i, frame_valid, (i == 7));
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (f_w[i] !== 4'(i)) begin
        n_errors++; $display("FAIL basic_f%0d: got %h expected %h", i, f_w[i], 4'(i));
      end
    end
    n_checks++;
    if (in_ready !== 1'b0 || written_mask !== 8'hFF) begin
      n_errors++; $display("FAIL basic_hold: in_ready=%b mask=%h expected 0/ff", in_ready, written_mask);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'($urandom), 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (f_w[i] !== exp_f[i]) begin
          n_errors++; $display("FAIL hold_f%0d: got %h expected %h", i, f_w[i], exp_f[i]);
        end
      end
      n_checks++;
      if (written_mask !== 8'hFF || frame_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_flags: mask=%h fv=%b rdy=%b expected ff/1/0", written_mask, frame_valid, in_ready);
      end
    end
    step(1'b1, 3'd0, 4'hF, 1'b1, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0 || written_mask !== 8'h00 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_accept: fv=%b mask=%h rdy=%b expected 0/00/1", frame_valid, written_mask, in_ready);
    end
    n_checks++;
    if (f_w[0] !== exp_f[0]) begin
      n_errors++; $display("FAIL hold_keep_f0: got %h expected %h", f_w[0], exp_f[0]);
    end
  endtask

  task automatic test_dup();
    int order [7] = '{0, 1, 3, 4, 5, 6, 7};
    step(1'b1, 3'b010, 4'hA, 1'b0, 1'b0);
    n_checks++;
    if (dup_err !== 1'b0 || f_w[2] !== 4'hA) begin
      n_errors++; $display("FAIL dup_first: dup=%b f2=%h expected 0/a", dup_err, f_w[2]);
    end
    step(1'b1, 3'b010, 4'hB, 1'b0, 1'b0);
    n_checks++;
    if (dup_err !== 1'b1 || f_w[2] !== 4'hB) begin
      n_errors++; $display("FAIL dup_second: dup=%b f2=%h expected 1/b", dup_err, f_w[2]);
    end
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 3'(ch2code[order[k]]), 4'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (frame_valid !== (k == 6)) begin
        n_errors++; $display("FAIL dup_fv_k%0d: got %b expected %b", k, frame_valid, (k == 6));
      end
    end
    n_checks++;
    if (f_w[2] !== 4'hB) begin
      n_errors++; $display("FAIL dup_f2_final: got %h expected b", f_w[2]);
    end
    step(1'b0, 3'd0, 4'h0, 1'b1, 1'b1);
    n_checks++;
    if (dup_err !== 1'b0) begin
      n_errors++; $display("FAIL dup_clear: got %b expected 0", dup_err);
    end
  endtask

  task automatic test_dup_with_clr();
    step(1'b1, 3'b111, 4'h3, 1'b0, 1'b0);
    step(1'b1, 3'b111, 4'h4, 1'b0, 1'b1);
    n_checks++;
    if (dup_err !== 1'b1) begin
      n_errors++; $display("FAIL dup_clr_same_cycle: got %b expected 1", dup_err);
    end
    step(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if (dup_err !== 1'b0) begin
      n_errors++; $display("FAIL dup_clr_after: got %b expected 0", dup_err);
    end
    finish_and_accept();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int fr_i = 0; fr_i < 3; fr_i++) begin
      for (int j = 0; j < 9; j++) begin
        step(1'b1, 3'(ch2code[j % 8]), 4'($urandom), 1'b1, 1'b0);
        if (frame_valid === 1'b1) pulses++;
        n_checks++;
        if (frame_valid !== (j == 7)) begin
          n_errors++; $display("FAIL b2b_fv_f%0d_c%0d: got %b expected %b", fr_i, j, frame_valid, (j == 7));
        end
        if (j == 7) begin
          for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (f_w[i] !== exp_f[i]) begin
              n_errors++; $display("FAIL b2b_f%0d_f%0d: got %h expected %h", fr_i, i, f_w[i], exp_f[i]);
            end
          end
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_async_reset();
    for (int pass = 0; pass < 2; pass++) begin
      int nwr;
      nwr = (pass == 0) ? 4 : 8;
      for (int i = 0; i < nwr; i++) step(1'b1, 3'(ch2code[i]), 4'(i + 9), 1'b0, 1'b0);
      idle_inputs();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (f_w[i] !== 4'h0) begin
          n_errors++; $display("FAIL arst%0d_f%0d: got %h expected 0", pass, i, f_w[i]);
        end
      end
      n_checks++;
      if (written_mask !== 8'h00 || frame_valid !== 1'b0 || dup_err !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL arst%0d_flags: mask=%h fv=%b dup=%b rdy=%b expected 00/0/0/1",
                 pass, written_mask, frame_valid, dup_err, in_ready);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++) step(1'b1, 3'(ch2code[7 - i]), 4'(15 - i), 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_errors++; $display("FAIL arst_refill_fv: got %b expected 1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (f_w[i] !== 4'(8 + i)) begin
        n_errors++; $display("FAIL arst_refill_f%0d: got %h expected %h", i, f_w[i], 4'(8 + i));
      end
    end
    step(1'b0, 3'd0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom), 4'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (f_w[i] !== exp_f[i]) begin
          n_errors++; $display("FAIL rand_c%0d_f%0d: got %h expected %h", k, i, f_w[i], exp_f[i]);
        end
      end
      n_checks++;
      if (written_mask !== exp_mask() || frame_valid !== exp_fv ||
          in_ready !== !exp_fv || dup_err !== exp_dup) begin
        n_errors++;
        $display("FAIL rand_c%0d_flags: mask=%h fv=%b rdy=%b dup=%b expected %h/%b/%b/%b",
                 k, written_mask, frame_valid, in_ready, dup_err, exp_mask(), exp_fv, !exp_fv, exp_dup);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold();
    test_dup();
    test_dup_with_clr();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
